instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Instruction sequencer in front of the instruction decoder. It fetches 28-bit instructions from the instruction memory, starting at a programmed address, and presents each one to the decoder for exactly one issue cycle. It stalls on back-pressure and on in-flight matrix-vector multiplies, and terminates a chain on `END_CHAIN`, an illegal opcode, an address overflow or an abort.

## Interface

Parameters:
- `INSTR_WIDTH`, 28: instruction width; opcode is bits `[INSTR_WIDTH-1 -: OPCODE_WIDTH]`.
- `OPCODE_WIDTH`, 4: opcode field width.
- `IMEM_AWIDTH`, 8: instruction memory address width.
- `CNT_WIDTH`, 16: width of the issued-instruction counter.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `resetn`, input, 1: asynchronous active-low reset.
- `start`, input, 1: begin a chain; sampled only in IDLE.
- `start_pc`, input, `IMEM_AWIDTH`: first instruction address; sampled with `start`.
- `abort`, input, 1: cancel the chain; has priority over everything except reset.
- `imem_rd_en`, output, 1: instruction memory read strobe.
- `imem_addr`, output, `IMEM_AWIDTH`: read address.
- `imem_rdata`, input, `INSTR_WIDTH`: read data, valid 1 cycle after `imem_rd_en`.
- `instr_out`, output, `INSTR_WIDTH`: instruction to the decoder.
- `instr_valid`, output, 1: `instr_out` is being issued this cycle.
- `dec_stall`, input, 1: decoder not ready; an issue happens only when `instr_valid & ~dec_stall`.
- `mvm_done`, input, 1: single-cycle pulse; the matrix-vector unit has finished.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: 1-cycle pulse when the chain terminates.
- `err`, output, 1: sticky error flag; cleared by the next accepted `start`.
- `issued_cnt`, output, `CNT_WIDTH`: instructions issued in the current chain; saturates at its maximum value.

## Operation

States are IDLE, FETCH, WAIT_MEM, ISSUE, WAIT_MVM and FINISH.

- **IDLE**
  - `start=1`: load `pc <= start_pc`, clear `issued_cnt` and `err`, go to FETCH.
- **FETCH**
  - Drive `imem_rd_en=1` and `imem_addr=pc`.
  - Go to WAIT_MEM.
- **WAIT_MEM**
  - Capture `instr_reg <= imem_rdata`.
  - Go to ISSUE.
- **ISSUE**
  - Drive `instr_valid=1`. While `dec_stall=1`, stay in ISSUE with `instr_out` held stable.
  - On issue, increment `issued_cnt`, then choose the next state by opcode:
    - 12 (`END_CHAIN`): FINISH.
    - 4 (`MV_MUL`): WAIT_MVM.
    - 13–15 (illegal): set `err`, go to FINISH. The illegal word is still presented and counted.
    - Otherwise: if `pc` is at its maximum value, set `err` and go to FINISH; there is no wrap-around. Else `pc <= pc+1` and go to FETCH.
- **WAIT_MVM**
  - Wait for `mvm_done`.
  - Then apply the same pc-overflow check, then `pc <= pc+1` and go to FETCH.
  - A `mvm_done` pulse arriving outside WAIT_MVM is ignored.
- **FINISH**
  - Pulse `done=1`.
  - Go to IDLE.

Other rules:
- `abort` in any non-IDLE state goes to IDLE on the next edge, with no `done` pulse and `err` unchanged. `instr_valid` and `imem_rd_en` are low from that edge on.
- `start` outside IDLE is ignored.
- `instr_out` always equals `instr_reg` and holds its value in IDLE.

## Timing

- Reset values: `state`=IDLE, `pc`=0, `instr_reg`=0, and all outputs 0. This includes `imem_addr`, `instr_out`, `issued_cnt`, `err`, `done`, `busy` and `instr_valid`.
- Reset asserted mid-chain: all of the above is cleared immediately (asynchronous); no `done` pulse is produced.
- `start` sampled at edge N:
  - `imem_rd_en` is high in cycle N+1.
  - `instr_valid` is high in cycle N+3.
- Unstalled non-MVM throughput: one instruction every 3 cycles.
- `MV_MUL` with `mvm_done` in cycle M: FETCH of the next instruction in cycle M+1.
- `END_CHAIN` issued in cycle K: `done` high in K+1, `busy` low in K+2.
- Outputs come directly from registers or are decoded from state only. There is no combinational path from any input to any output.

## Test plan

- `start_pc`=0x10; memory holds `VV_ADD`, `V_RELU`, `END_CHAIN`. Required: 3 issues at cycles 3, 6 and 9 after start; `done` at cycle 10; `issued_cnt`=3; `err`=0.
- `MV_MUL` at 0x00 with `mvm_done` 20 cycles after its issue. Required: FETCH of 0x01 exactly 1 cycle after `mvm_done`; an earlier stray `mvm_done` pulse sent during WAIT_MEM is ignored.
- `dec_stall` high for 5 cycles during an ISSUE. Required: `instr_valid` high for 6 cycles with `instr_out` stable; `issued_cnt` increments once.
- Opcode 14 at 0x02. Required: `err`=1, `done` pulse, `issued_cnt`=3. A following `start` clears `err`.
- `start_pc`=0xFF holding `VV_MUL`. Required: `err`=1, `done` pulse, no FETCH of address 0x00.
- `abort` during WAIT_MVM, and separately `resetn` low during ISSUE. Required: IDLE on the next edge (abort) or immediately (reset); no `done` pulse; outputs at the reset values given above, with `issued_cnt` and `err` retained on abort.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches instructions from instruction memory and issues each one
// to the decoder, stalling on decoder back-pressure and on in-flight matrix-vector multiplies.
module instr_sequencer #(
   parameter int unsigned INSTR_WIDTH  = 28,
   parameter int unsigned OPCODE_WIDTH = 4,
   parameter int unsigned IMEM_AWIDTH  = 8,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic [IMEM_AWIDTH-1:0] start_pc_i,
   input  logic                   abort_i,
   output logic                   imem_rd_en_o,
   output logic [IMEM_AWIDTH-1:0] imem_addr_o,
   input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
   output logic [INSTR_WIDTH-1:0] instr_out_o,
   output logic                   instr_valid_o,
   input  logic                   dec_stall_i,
   input  logic                   mvm_done_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic [CNT_WIDTH-1:0]   issued_cnt_o
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StWaitMem,
      StIssue,
      StWaitMvm,
      StFinish
   } state_e;

   localparam logic [OPCODE_WIDTH-1:0] OpMvMul      = OPCODE_WIDTH'(4);
   localparam logic [OPCODE_WIDTH-1:0] OpEndChain   = OPCODE_WIDTH'(12);
   localparam logic [OPCODE_WIDTH-1:0] OpIllegalMin = OPCODE_WIDTH'(13);

   state_e                 state_q, state_d;
   logic [IMEM_AWIDTH-1:0] pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   err_q, err_d;

   logic [OPCODE_WIDTH-1:0] opcode;
   logic                    pc_at_max;
   logic [CNT_WIDTH-1:0]    cnt_inc;

   assign opcode    = instr_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];
   assign pc_at_max = &pc_q;
   assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (abort_i && (state_q != StIdle)) begin
         // Abort returns the datapath to its reset view; count and error are kept.
         state_d = StIdle;
         pc_d    = '0;
         instr_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  pc_d    = start_pc_i;
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  state_d = StFetch;
               end
            end
            StFetch:   state_d = StWaitMem;
            StWaitMem: begin
               instr_d = imem_rdata_i;
               state_d = StIssue;
            end
            StIssue: begin
               if (!dec_stall_i) begin
                  cnt_d = cnt_inc;
                  if (opcode == OpEndChain) begin
                     state_d = StFinish;
                  end else if (opcode == OpMvMul) begin
                     state_d = StWaitMvm;
                  end else if (opcode >= OpIllegalMin) begin
                     err_d   = 1'b1;
                     state_d = StFinish;
                  end else if (pc_at_max) begin
                     err_d   = 1'b1;
                     state_d = StFinish;
                  end else begin
                     pc_d    = pc_q + IMEM_AWIDTH'(1);
                     state_d = StFetch;
                  end
               end
            end
            StWaitMvm: begin
               if (mvm_done_i) begin
                  if (pc_at_max) begin
                     err_d   = 1'b1;
                     state_d = StFinish;
                  end else begin
                     pc_d    = pc_q + IMEM_AWIDTH'(1);
                     state_d = StFetch;
                  end
               end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         pc_q    <= '0;
         instr_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign imem_rd_en_o  = (state_q == StFetch);
   assign imem_addr_o   = pc_q;
   assign instr_out_o   = instr_q;
   assign instr_valid_o = (state_q == StIssue);
   assign busy_o        = (state_q != StIdle);
   assign done_o        = (state_q == StFinish);
   assign err_o         = err_q;
   assign issued_cnt_o  = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: table of short chains plus hand-written sequences
// for MV_MUL waits, decoder stalls, abort and asynchronous reset.
module tb_instr_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  start_pc;
   logic        abort;
   logic        imem_rd_en;
   logic [7:0]  imem_addr;
   logic [27:0] imem_rdata;
   logic [27:0] instr_out;
   logic        instr_valid;
   logic        dec_stall;
   logic        mvm_done;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] issued_cnt;

   instr_sequencer dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .start_pc_i   (start_pc),
      .abort_i      (abort),
      .imem_rd_en_o (imem_rd_en),
      .imem_addr_o  (imem_addr),
      .imem_rdata_i (imem_rdata),
      .instr_out_o  (instr_out),
      .instr_valid_o(instr_valid),
      .dec_stall_i  (dec_stall),
      .mvm_done_i   (mvm_done),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err),
      .issued_cnt_o (issued_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read instruction memory: data valid the cycle after the read strobe.
   logic [27:0] mem [0:255];
   always @(posedge clk) begin
      if (imem_rd_en) imem_rdata <= mem[imem_addr];
   end

   int total = 0;
   int bad   = 0;
   int cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   function automatic logic [27:0] w(input logic [3:0] op, input logic [23:0] pl);
      return {op, pl};
   endfunction

   typedef struct {
      logic [7:0]  pc;
      logic [27:0] words [3];
      int          exp_iss;
      int          exp_fetch;
      logic        exp_err;
      int          exp_first;
      int          exp_done;
   } vec_t;

   vec_t vecs [6];

   // Start a chain in the current cycle (cycle 0); returns at cycle 1.
   task automatic kick(input logic [7:0] pc);
      start_pc = pc;
      start    = 1'b1;
      cyc      = 0;
      step();
      start    = 1'b0;
   endtask

   initial begin
      logic [7:0]  a;
      logic [7:0]  last_addr;
      logic [27:0] held;
      int          first_iss, done_cyc, n_fetch, n_iss, n_valid, n_done, n_fetch0;
      logic        stable;

      vecs[0] = '{8'h10, '{w(4'd1, 24'hA01), w(4'd2, 24'hA02), w(4'd12, 24'hA03)}, 3, 3, 1'b0, 3, 10};
      vecs[1] = '{8'h00, '{w(4'd1, 24'hB01), w(4'd3, 24'hB02), w(4'd14, 24'hB03)}, 3, 3, 1'b1, 3, 10};
      vecs[2] = '{8'hFF, '{w(4'd5, 24'hC01), w(4'd0, 24'h0), w(4'd0, 24'h0)}, 1, 1, 1'b1, 3, 4};
      vecs[3] = '{8'h20, '{w(4'd12, 24'hD01), w(4'd0, 24'h0), w(4'd0, 24'h0)}, 1, 1, 1'b0, 3, 4};
      vecs[4] = '{8'h30, '{w(4'd13, 24'hE01), w(4'd0, 24'h0), w(4'd0, 24'h0)}, 1, 1, 1'b1, 3, 4};
      vecs[5] = '{8'h40, '{w(4'd0, 24'hF01), w(4'd15, 24'hF02), w(4'd0, 24'h0)}, 2, 2, 1'b1, 3, 7};

      for (int i = 0; i < 256; i++) mem[i] = '0;
      rst_n = 1'b0; start = 1'b0; start_pc = '0; abort = 1'b0;
      dec_stall = 1'b0; mvm_done = 1'b0; imem_rdata = '0; cyc = 0;

      step(); step();
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_done",  {31'd0, done}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_rden",  {31'd0, imem_rd_en}, 32'd0);
      chk("rst_addr",  {24'd0, imem_addr}, 32'd0);
      chk("rst_instr", {4'd0, instr_out}, 32'd0);
      chk("rst_cnt",   {16'd0, issued_cnt}, 32'd0);
      chk("rst_err",   {31'd0, err}, 32'd0);
      rst_n = 1'b1;
      step();

      // Table-driven chains.
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < 3; k++) begin
            a = vecs[i].pc + 8'(k);
            mem[a] = vecs[i].words[k];
         end
         first_iss = -1; done_cyc = -1; n_fetch = 0; n_iss = 0; n_fetch0 = 0; last_addr = '0;
         kick(vecs[i].pc);
         chk($sformatf("v%0d_err_clr", i), {31'd0, err}, 32'd0);
         while (done_cyc < 0 && cyc < 100) begin
            if (imem_rd_en) begin
               n_fetch++;
               last_addr = imem_addr;
               if (imem_addr == 8'h00 && vecs[i].pc != 8'h00) n_fetch0++;
            end
            if (instr_valid && !dec_stall) begin
               n_iss++;
               if (first_iss < 0) first_iss = cyc;
            end
            if (done) done_cyc = cyc;
            else step();
         end
         chk($sformatf("v%0d_first_iss", i), first_iss, vecs[i].exp_first);
         chk($sformatf("v%0d_done_cyc", i), done_cyc, vecs[i].exp_done);
         chk($sformatf("v%0d_n_iss", i), n_iss, vecs[i].exp_iss);
         chk($sformatf("v%0d_n_fetch", i), n_fetch, vecs[i].exp_fetch);
         chk($sformatf("v%0d_last_addr", i), {24'd0, last_addr},
             {24'd0, vecs[i].pc + 8'(vecs[i].exp_fetch - 1)});
         chk($sformatf("v%0d_fetch0", i), n_fetch0, 0);
         step();
         chk($sformatf("v%0d_busy_after", i), {31'd0, busy}, 32'd0);
         chk($sformatf("v%0d_done_after", i), {31'd0, done}, 32'd0);
         chk($sformatf("v%0d_cnt", i), {16'd0, issued_cnt}, vecs[i].exp_iss);
         chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
         chk($sformatf("v%0d_instr_hold", i), {4'd0, instr_out},
             {4'd0, vecs[i].words[vecs[i].exp_iss - 1]});
         step();
      end

      // MV_MUL at 0x00 with a stray mvm_done in WAIT_MEM and the real one 20 cycles after issue.
      mem[8'h00] = w(4'd4, 24'h111);
      mem[8'h01] = w(4'd12, 24'h222);
      kick(8'h00);
      step();                              // cycle 2: WAIT_MEM
      mvm_done = 1'b1;
      step();                              // cycle 3: ISSUE
      mvm_done = 1'b0;
      chk("mvm_issue", {31'd0, instr_valid}, 32'd1);
      n_fetch = 0;
      for (int c = 4; c <= 23; c++) begin
         step();
         if (imem_rd_en) n_fetch++;
         if (c == 23) mvm_done = 1'b1;
      end
      chk("mvm_no_early_fetch", n_fetch, 0);
      step();                              // cycle 24
      mvm_done = 1'b0;
      chk("mvm_fetch_next", {31'd0, imem_rd_en}, 32'd1);
      chk("mvm_fetch_addr", {24'd0, imem_addr}, 32'h01);
      step(); step();                      // cycle 26: ISSUE END_CHAIN
      chk("mvm_end_issue", {31'd0, instr_valid}, 32'd1);
      step();
      chk("mvm_done", {31'd0, done}, 32'd1);
      chk("mvm_cnt", {16'd0, issued_cnt}, 32'd2);
      step(); step();

      // Decoder stall for 5 cycles during the first ISSUE.
      mem[8'h50] = w(4'd1, 24'h333);
      mem[8'h51] = w(4'd12, 24'h444);
      kick(8'h50);
      step(); step();                      // cycle 3
      n_valid = 0; stable = 1'b1; held = instr_out;
      for (int c = 3; c <= 9; c++) begin
         if (instr_valid) n_valid++;
         if (instr_valid && instr_out !== w(4'd1, 24'h333)) stable = 1'b0;
         if (c == 8) chk("stall_cnt_before", {16'd0, issued_cnt}, 32'd0);
         if (c == 9) chk("stall_cnt_after", {16'd0, issued_cnt}, 32'd1);
         dec_stall = (c <= 7);
         step();
      end
      dec_stall = 1'b0;
      chk("stall_valid_cycles", n_valid, 6);
      chk("stall_instr_stable", {31'd0, stable}, 32'd1);
      chk("stall_instr_val", {4'd0, held}, {4'd0, w(4'd1, 24'h333)});
      n_done = 0;
      for (int c = 0; c < 8; c++) begin
         if (done) n_done++;
         step();
      end
      chk("stall_done_once", n_done, 1);
      chk("stall_cnt_final", {16'd0, issued_cnt}, 32'd2);

      // Abort during WAIT_MVM.
      mem[8'h60] = w(4'd4, 24'h555);
      kick(8'h60);
      step(); step(); step(); step(); step(); // cycle 6: WAIT_MVM
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy",  {31'd0, busy}, 32'd0);
      chk("abort_valid", {31'd0, instr_valid}, 32'd0);
      chk("abort_rden",  {31'd0, imem_rd_en}, 32'd0);
      chk("abort_addr",  {24'd0, imem_addr}, 32'd0);
      chk("abort_instr", {4'd0, instr_out}, 32'd0);
      chk("abort_cnt",   {16'd0, issued_cnt}, 32'd1);
      chk("abort_err",   {31'd0, err}, 32'd0);
      n_done = 0; n_fetch = 0;
      mvm_done = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (done) n_done++;
         if (imem_rd_en) n_fetch++;
         step();
         mvm_done = 1'b0;
      end
      chk("abort_no_done", n_done, 0);
      chk("abort_stays_idle", n_fetch, 0);

      // Asynchronous reset during ISSUE.
      mem[8'h70] = w(4'd1, 24'h666);
      mem[8'h71] = w(4'd12, 24'h777);
      kick(8'h70);
      step(); step();                      // cycle 3: ISSUE
      chk("rstmid_in_issue", {31'd0, instr_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_busy",  {31'd0, busy}, 32'd0);
      chk("rstmid_valid", {31'd0, instr_valid}, 32'd0);
      chk("rstmid_instr", {4'd0, instr_out}, 32'd0);
      chk("rstmid_addr",  {24'd0, imem_addr}, 32'd0);
      chk("rstmid_cnt",   {16'd0, issued_cnt}, 32'd0);
      chk("rstmid_err",   {31'd0, err}, 32'd0);
      step();
      rst_n = 1'b1;
      n_done = 0;
      for (int c = 0; c < 5; c++) begin
         if (done || busy) n_done++;
         step();
      end
      chk("rstmid_quiet", n_done, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
